deflate_fixed_stream_ctrl: RTL

Sequencing controller for the fixed-Huffman literal path of the compressor. It accepts a byte stream over a valid/ready handshake and frames each message as one final Deflate fixed-Huffman block: a 3-bit header, one literal code per byte (8- or 9-bit codes from the literal encoder), and the 7-bit end-of-block code. It packs the variable-length codes into 16-bit words for the downstream encryption/serializer stage. It owns the literal encoder's enable and applies backpressure in both directions.

---
 rtl/deflate_fixed_stream_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/deflate_fixed_stream_ctrl.sv
// Frames each message as one final fixed-Huffman Deflate block (header, literals, EOB) packed LSB-first into 16-bit words.
// Output is combinational from the bit buffer; in_ready depends only on state/cnt, so a stalled output throttles input once the buffer fills.
module deflate_fixed_stream_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] lit_count
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LIT, S_EOB, S_FLUSH} state_t;

  state_t      state_q;
  logic [31:0] buf_q, buf_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] lit_count_q;

  logic [8:0]  lit_code;
  logic [3:0]  lit_len;
  logic [7:0]  rev8;
  logic [8:0]  rev9;
  logic [8:0]  lit_bits;

  logic        app_en;
  logic [8:0]  app_bits;
  logic [3:0]  app_len;
  logic        drain;
  logic        eob_room;
  logic [31:0] merged;
  logic [5:0]  merged_cnt;

  always_comb begin
    if (in_data < 8'd144) begin
      lit_code = {1'b0, in_data + 8'd48};
      lit_len  = 4'd8;
    end else begin
      lit_code = {1'b0, in_data} + 9'd256;
      lit_len  = 4'd9;
    end
  end

  // Codes go out MSB first while the stream fills from bit 0, so reverse them.
  always_comb begin
    rev8 = '0;
    rev9 = '0;
    for (int i = 0; i < 8; i++) rev8[i] = lit_code[7-i];
    for (int i = 0; i < 9; i++) rev9[i] = lit_code[8-i];
    lit_bits = (lit_len == 4'd9) ? rev9 : {1'b0, rev8};
  end

  assign in_ready  = (state_q == S_LIT) && (cnt_q <= 6'd23);
  assign eob_room  = (cnt_q <= 6'd25);
  assign out_valid = (state_q == S_FLUSH) ||
                     (((state_q == S_HDR) || (state_q == S_LIT) || (state_q == S_EOB)) &&
                      (cnt_q >= 6'd16));
  assign out_last  = (state_q == S_FLUSH) && (cnt_q <= 6'd16);
  assign out_data  = buf_q[15:0];
  assign busy      = (state_q != S_IDLE);
  assign lit_count = lit_count_q;
  assign drain     = out_valid && out_ready;

  always_comb begin
    app_en   = 1'b0;
    app_bits = '0;
    app_len  = '0;
    case (state_q)
      S_HDR: begin
        app_en   = 1'b1;
        app_bits = 9'b0_0000_0011;
        app_len  = 4'd3;
      end
      S_LIT: begin
        if (in_valid && in_ready) begin
          app_en   = 1'b1;
          app_bits = lit_bits;
          app_len  = lit_len;
        end
      end
      S_EOB: begin
        if (eob_room) begin
          app_en   = 1'b1;
          app_bits = '0;
          app_len  = 4'd7;
        end
      end
      default: ;
    endcase
  end

  // Bits above cnt are kept zero, so the final word's padding comes for free.
  always_comb begin
    merged     = buf_q | ({23'd0, app_bits} << cnt_q);
    merged_cnt = cnt_q + (app_en ? {2'b00, app_len} : 6'd0);
    buf_d      = drain ? {16'd0, merged[31:16]} : merged;
    cnt_d      = drain ? (merged_cnt - 6'd16) : merged_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      lit_count_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid) state_q <= S_HDR;
        end
        S_HDR: begin
          state_q <= S_LIT;
        end
        S_LIT: begin
          if (in_valid && in_ready) begin
            lit_count_q <= lit_count_q + 16'd1;
            if (in_last) state_q <= S_EOB;
          end
        end
        S_EOB: begin
          if (eob_room) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          if (drain && out_last) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            lit_count_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
